violation_log_ctrl: RTL and testbench

Parametrised violation logger for the VRASED hardware monitor. Rising edges on any of NUM_SRC violation-reset strobes are captured with their CPU/DMA context and written as fixed-format records into an external log RAM. Simultaneous and back-to-back events are queued by priority rather than lost. The block tracks fill level and drops, and selects wrap-around or stop-when-full at run time.

---
 rtl/violation_log_ctrl.sv | 101 ++++++++++
 tb/tb_violation_log_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/violation_log_ctrl.sv
// violation_log_ctrl: captures rising edges of violation strobes with CPU/DMA context
// and drains them by priority into an external log RAM as fixed-format records.
module violation_log_ctrl #(
    parameter int NUM_SRC = 6,
    parameter int CODE_W = 3,
    parameter int ADDR_W = 16,
    parameter logic [NUM_SRC-1:0] DMA_MASK = 6'b111000,
    parameter logic [NUM_SRC-1:0] NOADDR_MASK = 6'b000100,
    parameter logic [NUM_SRC-1:0] WR_MASK = 6'b000001,
    parameter int DROP_W = 8,
    localparam int REC_W = CODE_W + 34
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_rst,
    input  logic [15:0]        pc,
    input  logic [15:0]        data_addr,
    input  logic               data_en,
    input  logic               data_wr,
    input  logic [15:0]        dma_addr,
    input  logic               dma_en,
    input  logic               clr,
    input  logic               wrap_en,
    output logic               log_we,
    output logic [ADDR_W-1:0]  log_waddr,
    output logic [REC_W-1:0]   log_wdata,
    output logic [ADDR_W:0]    log_count,
    output logic               log_full,
    output logic               log_wrapped,
    output logic [DROP_W-1:0]  drop_cnt
);
    localparam int SNAP_W = 34;
    localparam int SUM_W = DROP_W + CODE_W + 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [NUM_SRC-1:0] src_prev, pend, ev, svc, retrig;
    logic [SNAP_W-1:0]  snap [NUM_SRC];
    logic [SNAP_W-1:0]  cap_data [NUM_SRC];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [CODE_W-1:0]  sel;
    logic               stall, we_next;
    logic [SUM_W-1:0]   drop_sum;

    assign ev       = src_rst & ~src_prev;
    assign svc      = pend & (~pend + NUM_SRC'(1));
    assign retrig   = ev & pend & ~svc;
    assign log_full = log_count == DEPTH;
    assign stall    = log_full & ~wrap_en;
    assign we_next  = |pend & ~stall;
    assign drop_sum = SUM_W'(drop_cnt) + SUM_W'($countones(retrig)) + SUM_W'(|pend & stall);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cap
        assign cap_data[g] = NOADDR_MASK[g] ? {pc, 18'b0} :
                             DMA_MASK[g]    ? {pc, dma_addr, dma_en, 1'b0} :
                                              {pc, data_addr, data_en, WR_MASK[g] & data_wr};
    end

    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (pend[i]) sel = CODE_W'(i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_prev    <= '0;
            pend        <= '0;
            wr_ptr      <= '0;
            log_we      <= 1'b0;
            log_waddr   <= '0;
            log_wdata   <= '0;
            log_count   <= '0;
            log_wrapped <= 1'b0;
            drop_cnt    <= '0;
            for (int i = 0; i < NUM_SRC; i++) snap[i] <= '0;
        end else if (clr) begin
            src_prev    <= src_rst;
            pend        <= '0;
            wr_ptr      <= '0;
            log_we      <= 1'b0;
            log_count   <= '0;
            log_wrapped <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            src_prev <= src_rst;
            pend     <= (pend & ~svc) | ev;
            log_we   <= we_next;
            drop_cnt <= (drop_sum > SUM_W'({DROP_W{1'b1}})) ? '1 : drop_sum[DROP_W-1:0];
            // a re-trigger on a still-queued source keeps the first snapshot
            for (int i = 0; i < NUM_SRC; i++)
                if (ev[i] && !retrig[i]) snap[i] <= cap_data[i];
            if (we_next) begin
                log_waddr <= wr_ptr;
                log_wdata <= {sel, snap[sel]};
                wr_ptr    <= wr_ptr + ADDR_W'(1);
                if (log_full) log_wrapped <= 1'b1;
                else log_count <= log_count + (ADDR_W + 1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_violation_log_ctrl.sv
// tb_violation_log_ctrl: scoreboard bench for violation_log_ctrl with an 8-entry log.
module tb_violation_log_ctrl;
    localparam int AW = 3;
    localparam int RW = 37;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic [5:0]    src_rst = '0;
    logic [15:0]   pc = '0, data_addr = '0, dma_addr = '0;
    logic          data_en = 1'b0, data_wr = 1'b0, dma_en = 1'b0, clr = 1'b0, wrap_en = 1'b0;
    logic          log_we, log_full, log_wrapped;
    logic [AW-1:0] log_waddr;
    logic [RW-1:0] log_wdata;
    logic [AW:0]   log_count;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    violation_log_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .src_rst(src_rst), .pc(pc),
        .data_addr(data_addr), .data_en(data_en), .data_wr(data_wr),
        .dma_addr(dma_addr), .dma_en(dma_en), .clr(clr), .wrap_en(wrap_en),
        .log_we(log_we), .log_waddr(log_waddr), .log_wdata(log_wdata),
        .log_count(log_count), .log_full(log_full), .log_wrapped(log_wrapped),
        .drop_cnt(drop_cnt)
    );

    int n_chk = 0, n_fail = 0;
    logic [AW+RW-1:0] sb [$];
    logic [AW-1:0] exp_ptr = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic expect_rec(input logic [2:0] c, input logic [15:0] p, input logic [15:0] a,
                              input logic e, input logic w);
        sb.push_back({exp_ptr, c, p, a, e, w});
        exp_ptr++;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse(input int s, input logic [15:0] p);
        @(negedge clk);
        pc = p;
        src_rst[s] = 1'b1;
        @(negedge clk);
        src_rst[s] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_ptr = '0;
    endtask

    always @(posedge clk) begin
        #1;
        if (reset_n && log_we) begin
            chk("write_expected", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("record", {log_waddr, log_wdata}, sb.pop_front());
        end
    end

    initial begin
        #12;
        chk("rst_we", log_we, 0);
        chk("rst_waddr", log_waddr, 0);
        chk("rst_wdata", log_wdata, 0);
        chk("rst_count", log_count, 0);
        chk("rst_full", log_full, 0);
        chk("rst_wrapped", log_wrapped, 0);
        chk("rst_drop", drop_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // single event and latency
        pc = 16'h8000; data_addr = 16'h0200; data_en = 1'b1; data_wr = 1'b1;
        src_rst = 6'b000010;
        expect_rec(3'd1, 16'h8000, 16'h0200, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("lat_edge_n", log_we, 0);
        src_rst = '0;
        @(posedge clk); #1;
        chk("lat_we", log_we, 1);
        chk("count_1", log_count, 1);
        @(posedge clk); #1;
        chk("we_one_cycle", log_we, 0);
        drain();

        // simultaneous events drain back to back in code order
        pc = 16'h4000; data_addr = 16'h1234; dma_addr = 16'hA5A5; dma_en = 1'b1;
        src_rst = 6'b100101;
        expect_rec(3'd0, 16'h4000, 16'h1234, 1'b1, 1'b1);
        expect_rec(3'd2, 16'h4000, 16'h0000, 1'b0, 1'b0);
        expect_rec(3'd5, 16'h4000, 16'hA5A5, 1'b1, 1'b0);
        @(posedge clk); #1;
        src_rst = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("b2b_we", log_we, 1);
        end
        @(posedge clk); #1;
        chk("b2b_end", log_we, 0);
        drain();
        chk("count_4", log_count, 4);

        // held level logs once
        @(negedge clk);
        pc = 16'h5000; dma_addr = 16'hBEEF; dma_en = 1'b0;
        src_rst = 6'b001000;
        expect_rec(3'd3, 16'h5000, 16'hBEEF, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        src_rst = '0;
        drain();
        chk("count_held", log_count, 5);
        clear();
        chk("clr_count", log_count, 0);

        // re-trigger of queued source 2 drops; source 1 re-captures while serviced
        data_addr = 16'h0111;
        expect_rec(3'd0, 16'h6000, 16'h0111, 1'b1, 1'b1);
        expect_rec(3'd1, 16'h6000, 16'h0111, 1'b1, 1'b0);
        expect_rec(3'd1, 16'h6200, 16'h0111, 1'b1, 1'b0);
        expect_rec(3'd2, 16'h6000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk); pc = 16'h6000; src_rst = 6'b000111;
        @(negedge clk); pc = 16'h6100; src_rst = 6'b000000;
        @(negedge clk); pc = 16'h6200; src_rst = 6'b000110;
        @(negedge clk); src_rst = '0;
        drain();
        chk("retrig_drop", drop_cnt, 1);
        chk("retrig_count", log_count, 4);

        // stop-when-full
        clear();
        wrap_en = 1'b0; dma_addr = 16'hC000; dma_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) expect_rec(3'd4, 16'h1000 + 16'(i), 16'hC000, 1'b1, 1'b0);
            pulse(4, 16'h1000 + 16'(i));
        end
        drain();
        chk("stop_full", log_full, 1);
        chk("stop_count", log_count, 8);
        chk("stop_drop", drop_cnt, 2);
        chk("stop_wrapped", log_wrapped, 0);

        // wrap-around
        clear();
        wrap_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_rec(3'd4, 16'h2000 + 16'(i), 16'hC000, 1'b1, 1'b0);
            pulse(4, 16'h2000 + 16'(i));
        end
        drain();
        chk("wrap_count", log_count, 8);
        chk("wrap_flag", log_wrapped, 1);
        chk("wrap_drop", drop_cnt, 0);
        chk("wrap_last_addr", log_waddr, 1);

        // clr during a burst discards it
        @(negedge clk);
        src_rst = 6'b000111; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; src_rst = '0; exp_ptr = '0;
        repeat (6) @(negedge clk);
        chk("clrb_count", log_count, 0);
        chk("clrb_full", log_full, 0);
        chk("clrb_wrapped", log_wrapped, 0);
        chk("clrb_drop", drop_cnt, 0);
        chk("clrb_we", log_we, 0);

        // async reset mid-drain
        @(negedge clk);
        pc = 16'h7000; data_addr = 16'h0ABC;
        src_rst = 6'b000111;
        expect_rec(3'd0, 16'h7000, 16'h0ABC, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_we", log_we, 0);
        chk("arst_count", log_count, 0);
        chk("arst_waddr", log_waddr, 0);
        chk("arst_wdata", log_wdata, 0);
        src_rst = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_after_count", log_count, 0);
        chk("arst_sb_empty", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
